// File: rtl/drv_segment_bin2dec.sv
// rtl/drv_segment_bin2dec.sv - sequential binary-to-BCD converter (double dabble, one bit per clock)
// Optional leading-zero blanking enabled by DRV_SEGMENT_BLANK_EN.
module drv_segment_bin2dec #(
    parameter int p_count = 4,
    parameter int p_width = 14
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [p_width-1:0]        i_value,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_ovf,
    output logic [p_count-1:0][3:0]   o_digit,
    output logic [p_count-1:0]        o_blank
);

    localparam int c_cnt_w = $clog2(p_width + 1);

    typedef enum logic [1:0] {
        st_idle,
        st_shift,
        st_done
    } state_t;

    state_t                    state_q;
    logic [p_width-1:0]        shift_q;
    logic [p_count-1:0][3:0]   bcd_q;
    logic [p_count-1:0][3:0]   bcd_adj;
    logic [p_count-1:0][3:0]   bcd_next;
    logic                      ovf_q;
    logic                      carry_out;
    logic [c_cnt_w-1:0]        cnt_q;

    // Add-3 correction is per digit; carries never ripple between digits.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < p_count; i++) begin
            if (bcd_q[i] >= 4'd5) begin
                bcd_adj[i] = bcd_q[i] + 4'd3;
            end
        end
        carry_out = bcd_adj[p_count-1][3];
        bcd_next  = {bcd_adj[p_count-1:0], shift_q[p_width-1]} & {(4*p_count){1'b1}};
    end

`ifdef DRV_SEGMENT_BLANK_EN
    logic [p_count-1:0] blank_calc;
    logic               zero_run;

    always_comb begin
        blank_calc = '0;
        zero_run   = 1'b1;
        for (int i = p_count - 1; i > 0; i--) begin
            zero_run      = zero_run & (bcd_q[i] == 4'd0);
            blank_calc[i] = zero_run;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_blank <= '0;
        end else if (state_q == st_done) begin
            o_blank <= ovf_q ? '0 : blank_calc;
        end
    end
`else
    assign o_blank = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= st_idle;
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_ovf   <= 1'b0;
            o_digit <= '0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                st_idle: begin
                    if (i_start) begin
                        shift_q <= i_value;
                        bcd_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= c_cnt_w'(p_width);
                        o_busy  <= 1'b1;
                        state_q <= st_shift;
                    end
                end
                st_shift: begin
                    bcd_q   <= bcd_next;
                    shift_q <= shift_q << 1;
                    ovf_q   <= ovf_q | carry_out;
                    cnt_q   <= cnt_q - c_cnt_w'(1);
                    // busy drops as we enter DONE so a start in DONE is visibly ignored
                    if (cnt_q == c_cnt_w'(1)) begin
                        o_busy  <= 1'b0;
                        state_q <= st_done;
                    end
                end
                st_done: begin
                    o_digit <= ovf_q ? {p_count{4'd9}} : bcd_q;
                    o_ovf   <= ovf_q;
                    o_done  <= 1'b1;
                    state_q <= st_idle;
                end
                default: state_q <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_drv_segment_bin2dec.sv
// tb/tb_drv_segment_bin2dec.sv - directed self-checking bench for drv_segment_bin2dec
module tb_drv_segment_bin2dec;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [13:0]       value;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [3:0][3:0]   digit;
    logic [3:0]        blank;

    int n_tests;
    int n_failed;

    drv_segment_bin2dec #(.p_count(4), .p_width(14)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_value (value),
        .o_busy  (busy),
        .o_done  (done),
        .o_ovf   (ovf),
        .o_digit (digit),
        .o_blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_blank(input logic [3:0] mask);
`ifdef DRV_SEGMENT_BLANK_EN
        return mask;
`else
        return 4'b0000 & mask;
`endif
    endfunction

    // mode 0: plain, 1: start pulse while busy, 2: reset mid-SHIFT
    task automatic convert(input string tag, input logic [13:0] v, input int mode,
                           input logic [15:0] exp_dig, input logic exp_ovf,
                           input logic [3:0] exp_blk);
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic [15:0] got_dig;
        logic        got_ovf;
        logic [3:0]  got_blk;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        got_dig  = 16'hxxxx;
        got_ovf  = 1'bx;
        got_blk  = 4'hx;
        start = 1'b1;
        value = v;
        for (int k = 0; k < 22; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                start = 1'b0;
                value = 14'h1555;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
                got_dig = digit;
                got_ovf = ovf;
                got_blk = blank;
            end
            if (mode == 1 && k == 4) begin
                start = 1'b1;
                value = 14'd7;
            end
            if (mode == 1 && k == 5) start = 1'b0;
            if (mode == 2 && k == 6) begin
                #3 rst_n = 1'b0;
                #1;
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_digit"}, 32'(digit), 32'd0);
                check({tag, "_rst_ovf"}, 32'(ovf), 32'd0);
            end
            if (mode == 2 && k == 8) rst_n = 1'b1;
        end
        if (mode == 2) begin
            check({tag, "_no_done"}, 32'(done_cnt), 32'd0);
            check({tag, "_digit_after"}, 32'(digit), 32'd0);
        end else begin
            check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
            check({tag, "_latency"}, 32'(done_at), 32'd15);
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd14);
            check({tag, "_digit"}, 32'(got_dig), 32'(exp_dig));
            check({tag, "_ovf"}, 32'(got_ovf), 32'(exp_ovf));
            check({tag, "_blank"}, 32'(got_blk), 32'(exp_blk));
            check({tag, "_digit_hold"}, 32'(digit), 32'(exp_dig));
        end
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_digit", 32'(digit), 32'd0);
        check("reset_blank", 32'(blank), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        convert("v1234", 14'd1234, 0, 16'h1234, 1'b0, exp_blank(4'b0000));

        // asynchronous reset mid-cycle clears outputs without a clock edge
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_digit", 32'(digit), 32'd0);
        check("async_rst_ovf", 32'(ovf), 32'd0);
        check("async_rst_blank", 32'(blank), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        convert("v0", 14'd0, 0, 16'h0000, 1'b0, exp_blank(4'b1110));
        convert("v9999", 14'd9999, 0, 16'h9999, 1'b0, exp_blank(4'b0000));
        convert("v10000", 14'd10000, 0, 16'h9999, 1'b1, 4'b0000);
        convert("v16383", 14'd16383, 0, 16'h9999, 1'b1, 4'b0000);
        convert("v42", 14'd42, 0, 16'h0042, 1'b0, exp_blank(4'b1100));
        convert("busy_start", 14'd500, 1, 16'h0500, 1'b0, exp_blank(4'b1000));
        convert("rst_shift", 14'd8765, 2, 16'h0000, 1'b0, 4'b0000);
        convert("v31", 14'd31, 0, 16'h0031, 1'b0, exp_blank(4'b1100));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
